lsu_mem_port: RTL
=================

Name: lsu_mem_port

Overview:
- Multi-cycle load/store unit between the execute stage and the data memory bus.
- Accepts one access per transaction: byte address plus store data from EXU's alu_result/rs2 path.
- Issues a word-aligned request with byte strobes on a valid/ready memory bus, waits for the response, and returns sign/zero-extended load data or store completion to writeback.
- Detects misaligned accesses and bus timeouts, reporting each as an error instead of hanging the core.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles in WAIT before a timeout error is flagged; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  access request from EXU
- in_ready  out  1  LSU can accept a request
- in_addr  in  32  byte address
- in_wdata  in  32  store data, LSB-aligned
- in_wen  in  1  1 = store, 0 = load
- in_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- in_unsigned  in  1  load zero-extend (LBU/LHU)
- out_valid  out  1  result available
- out_ready  in  1  writeback accepts result
- out_rdata  out  32  extended load data; 0 for stores and errors
- out_err  out  1  misaligned, illegal size, bus error or timeout
- req_valid  out  1  memory request valid
- req_ready  in  1  memory accepts request
- req_addr  out  32  in_addr with bits [1:0] forced to 0
- req_wen  out  1  store request
- req_wdata  out  32  lane-replicated store data
- req_wstrb  out  4  byte strobes; 0000 for loads
- rsp_valid  in  1  memory response valid
- rsp_ready  out  1  LSU accepts response
- rsp_rdata  in  32  full word read data
- rsp_err  in  1  bus error

Behaviour:
- Reset: state IDLE, drain_pending=0, all captured registers 0.
  - While rst is high, every output is 0.
  - in_ready=1 from the first cycle after release.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - in_ready = !drain_pending.
  - On in_valid&&in_ready, capture addr, size, wen, unsigned and wdata.
  - Misaligned check: half with addr[0]=1, word with addr[1:0]!=0, or size=3 → DONE with err=1. No bus access is made.
  - Otherwise → REQ.
- REQ:
  - req_valid=1; all req_* fields come from registers and stay stable until the handshake.
  - On req_ready → WAIT, watchdog counter cleared.
- WAIT:
  - rsp_ready=1; counter increments each cycle.
  - On rsp_valid → DONE with err=rsp_err and data=extract(rsp_rdata).
  - If TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1 without a response → DONE with err=1 and drain_pending set.
  - If rsp_valid and the timeout occur in the same cycle, the response wins.
- DONE:
  - out_valid=1; out_rdata/out_err are held stable.
  - On out_ready → IDLE.
- Drain: while drain_pending=1, rsp_ready=1 in all states. The next rsp handshake is discarded and clears drain_pending. This stops a late response from being matched to a new request.
- Store lanes (o = addr[1:0]):
  - byte: wdata={4{wdata[7:0]}}, wstrb=0001<<o
  - half: wdata={2{wdata[15:0]}}, wstrb=0011<<o
  - word: wdata as-is, wstrb=1111
- Load extract:
  - sh = rsp_rdata >> (8*o).
  - byte: sign- or zero-extend sh[7:0]; half: same for sh[15:0]; word: sh.
  - Stores return out_rdata=0; any error forces out_rdata=0.
- Latency: request accepted at cycle 0 → req_valid at cycle 1. With req_ready at cycle 1 and rsp_valid at cycle 2, out_valid is at cycle 3. A misaligned access gives out_valid at cycle 1.
- Throughput: one outstanding transaction; no new acceptance until DONE hands off.
- rst asserted mid-transaction aborts immediately to IDLE and clears drain_pending. The bus side must be reset together with the LSU.

Test Plan:
- Word load, addr 0x80000104, rsp_rdata 0xDEADBEEF, req_ready and rsp_valid immediate → req_addr 0x80000104, wstrb 0000; out_rdata 0xDEADBEEF, err 0; out_valid 3 cycles after acceptance.
- Byte loads from addr 0x80000003 with rsp_rdata 0x80FF1234 → LB gives 0xFFFFFF80, LBU gives 0x00000080. LH at 0x80000002 gives 0xFFFF80FF.
- Store half 0x0000ABCD to addr 0x80000006 → req_addr 0x80000004, req_wdata 0xABCDABCD, wstrb 1100, req_wen 1; out_rdata 0, err 0.
- Misaligned word load at 0x80000002, then size=3 → each gives out_err=1 after 1 cycle, with req_valid never asserted.
- TIMEOUT_CYCLES=4 with no rsp_valid → out_err=1 after 4 WAIT cycles. Then:
  - next request is held with in_ready=0;
  - late rsp_valid is consumed with rsp_ready=1;
  - in_ready returns to 1 and the next load completes correctly.
- Backpressure: req_ready low 3 cycles, out_ready low 2 cycles, rst pulsed during WAIT → req_* and out_* fields stay stable while stalled; after reset the state is IDLE with in_ready=1 and req_valid=0.

Source files
------------

// File: rtl/lsu_mem_port.sv
// Load/store unit bridging execute to a valid/ready data memory bus.
// One outstanding access; misalignment and bus timeouts surface as errors.
module lsu_mem_port #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic        in_wen,
    input  logic [1:0]  in_size,
    input  logic        in_unsigned,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic        out_err,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_addr,
    output logic        req_wen,
    output logic [31:0] req_wdata,
    output logic [3:0]  req_wstrb,
    input  logic        rsp_valid,
    output logic        rsp_ready,
    input  logic [31:0] rsp_rdata,
    input  logic        rsp_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

    state_e      state_q;
    logic        drain_q;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        wen_q;
    logic        uns_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] cnt_q;

    logic        misal;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_wstrb;
    logic [31:0] sh;
    logic [31:0] ext;
    logic        tmo;
    logic        live;

    always_comb begin
        misal = (in_size == 2'd3)
             || (in_size == 2'd1 && in_addr[0])
             || (in_size == 2'd2 && in_addr[1:0] != 2'b00);
    end

    always_comb begin
        lane_wdata = in_wdata;
        lane_wstrb = 4'b1111;
        unique case (in_size)
            2'd0: begin
                lane_wdata = {4{in_wdata[7:0]}};
                lane_wstrb = 4'b0001 << in_addr[1:0];
            end
            2'd1: begin
                lane_wdata = {2{in_wdata[15:0]}};
                lane_wstrb = 4'b0011 << in_addr[1:0];
            end
            default: begin
                lane_wdata = in_wdata;
                lane_wstrb = 4'b1111;
            end
        endcase
    end

    always_comb begin
        sh  = rsp_rdata >> {addr_q[1:0], 3'b000};
        ext = sh;
        unique case (size_q)
            2'd0: ext = uns_q ? {24'b0, sh[7:0]}
                              : {{24{sh[7]}}, sh[7:0]};
            2'd1: ext = uns_q ? {16'b0, sh[15:0]}
                              : {{16{sh[15]}}, sh[15:0]};
            default: ext = sh;
        endcase
    end

    assign tmo = (TIMEOUT_CYCLES != 0)
              && (cnt_q == TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            drain_q <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            wen_q   <= 1'b0;
            uns_q   <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            // A late response after a timeout is swallowed here.
            if (drain_q && rsp_valid) drain_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (in_valid && !drain_q) begin
                        addr_q  <= in_addr;
                        size_q  <= in_size;
                        wen_q   <= in_wen;
                        uns_q   <= in_unsigned;
                        wdata_q <= lane_wdata;
                        wstrb_q <= in_wen ? lane_wstrb : 4'b0000;
                        rdata_q <= '0;
                        err_q   <= misal;
                        state_q <= misal ? DONE : REQ;
                    end
                end
                REQ: begin
                    if (req_ready) begin
                        cnt_q   <= '0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q + 32'd1;
                    if (rsp_valid) begin
                        err_q   <= rsp_err;
                        rdata_q <= (rsp_err || wen_q) ? '0 : ext;
                        state_q <= DONE;
                    end else if (tmo) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                        drain_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign live      = !rst;
    assign in_ready  = live && state_q == IDLE && !drain_q;
    assign req_valid = live && state_q == REQ;
    assign req_addr  = live ? {addr_q[31:2], 2'b00} : 32'd0;
    assign req_wen   = live && wen_q;
    assign req_wdata = live ? wdata_q : 32'd0;
    assign req_wstrb = live ? wstrb_q : 4'd0;
    assign rsp_ready = live && (state_q == WAIT || drain_q);
    assign out_valid = live && state_q == DONE;
    assign out_rdata = live ? rdata_q : 32'd0;
    assign out_err   = live && err_q;

endmodule
